lapido_scoreboard: RTL

Parametrised pipeline-interlock scoreboard for the LAPIDO core, replacing the fixed one-entry load-use check and the separate combinational forwarding compare with one tracked structure. It records every in-flight register write from EX through WB, raises a stall for the instruction in ID when a needed result is not yet forwardable, and produces registered forwarding selects that are valid during that instruction's EX cycle. Pipeline depth and load latency are parameters, so deeper MEM or multi-cycle memory configurations reuse the same block.

---
 rtl/lapido_scoreboard.sv | 95 +++++++++
 1 files changed

// File: rtl/lapido_scoreboard.sv
// Pipeline-interlock scoreboard: tracks in-flight register writes, raises load-use stalls
// and produces registered EX-cycle forwarding selects. Optional stall counter: LAPIDO_SB_PERF_EN.
module lapido_scoreboard #(
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 3,
  parameter int FW_W       = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rs,
  input  logic [ADDR_W-1:0] issue_rt,
  input  logic              issue_use_rs,
  input  logic              issue_use_rt,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_is_load,
  input  logic              flush,
  output logic              stall,
`ifdef LAPIDO_SB_PERF_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic [FW_W-1:0]   fwd_a,
  output logic [FW_W-1:0]   fwd_b
);

  // Only stages 1..DEPTH-1 are stored: a write in stage DEPTH is in the register
  // file by the consumer's EX cycle, so it can never be a forwarding source.
  logic [DEPTH-1:1]             ent_valid;
  logic [DEPTH-1:1]             ent_load;
  logic [DEPTH-1:1][ADDR_W-1:0] ent_rd;

  logic            hit_a, hit_b;
  logic            rdy_a, rdy_b;
  logic [FW_W-1:0] sel_a, sel_b;
  logic            accept;

  // Scan oldest to youngest so the youngest matching entry overrides.
  always_comb begin
    hit_a = 1'b0;
    rdy_a = 1'b1;
    sel_a = '0;
    hit_b = 1'b0;
    rdy_b = 1'b1;
    sel_b = '0;
    for (int k = DEPTH-1; k >= 1; k--) begin
      if (issue_use_rs && (issue_rs != '0) && ent_valid[k] && (ent_rd[k] == issue_rs)) begin
        hit_a = 1'b1;
        sel_a = FW_W'(k+1);
        rdy_a = !ent_load[k] || ((k+1) >= LOAD_READY);
      end
      if (issue_use_rt && (issue_rt != '0) && ent_valid[k] && (ent_rd[k] == issue_rt)) begin
        hit_b = 1'b1;
        sel_b = FW_W'(k+1);
        rdy_b = !ent_load[k] || ((k+1) >= LOAD_READY);
      end
    end
  end

  assign stall  = issue_valid && !flush && ((hit_a && !rdy_a) || (hit_b && !rdy_b));
  assign accept = issue_valid && !flush && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      ent_load  <= '0;
      ent_rd    <= '0;
      fwd_a     <= '0;
      fwd_b     <= '0;
    end else begin
      for (int k = DEPTH-1; k >= 2; k--) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_load[k]  <= ent_load[k-1];
        ent_rd[k]    <= ent_rd[k-1];
      end
      ent_valid[1] <= accept && issue_we && (issue_rd != '0);
      ent_load[1]  <= issue_is_load;
      ent_rd[1]    <= issue_rd;
      fwd_a        <= accept ? sel_a : '0;
      fwd_b        <= accept ? sel_b : '0;
    end
  end

`ifdef LAPIDO_SB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
